// File: rtl/gps_timing_pkg.sv
// Shared types and sizing helpers for the GPS timing path.
package gps_timing_pkg;

    typedef enum logic {
        S_ACQUIRE = 1'b0,
        S_TRACK   = 1'b1
    } pps_qual_state_e;

    // Width needed to hold the longest period that can still be judged.
    function automatic int period_width(input int clocks_per_second, input int tolerance);
        return $clog2(clocks_per_second + tolerance + 1);
    endfunction

endpackage

// File: rtl/pps_sync_filter.sv
// Synchronizes the raw PPS into clk_tf and emits one accept per high interval
// that lasts at least MinPulseWidth cycles.
module pps_sync_filter #(
    parameter int SyncStages    = 2,
    parameter int MinPulseWidth = 192
) (
    input  logic clk_tf,
    input  logic rst,
    input  logic pps_raw,
    output logic accept
);

    localparam int HW = $clog2(MinPulseWidth + 1);
    localparam logic [HW-1:0] HiMax  = HW'(MinPulseWidth);
    localparam logic [HW-1:0] HiFire = HW'(MinPulseWidth - 1);

    logic [SyncStages-1:0] sync_q;
    logic                  pps_s;
    logic [HW-1:0]         hi_cnt;

    always_ff @(posedge clk_tf or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], pps_raw};
        end
    end

    assign pps_s = sync_q[SyncStages-1];

    // Saturating the count keeps a long-held input from ever firing twice.
    always_ff @(posedge clk_tf or posedge rst) begin
        if (rst) begin
            hi_cnt <= '0;
        end else if (!pps_s) begin
            hi_cnt <= '0;
        end else if (hi_cnt != HiMax) begin
            hi_cnt <= hi_cnt + HW'(1);
        end
    end

    assign accept = pps_s && (hi_cnt == HiFire);

endmodule

// File: rtl/pps_qualifier.sv
// Qualifies the GPS PPS: width filter, period check, lock tracking, and a
// fixed-width output pulse only for in-period edges while locked.
module pps_qualifier
    import gps_timing_pkg::*;
#(
    parameter int ClocksPerSecond = 19200000,
    parameter int PeriodTolerance = 192,
    parameter int MinPulseWidth   = 192,
    parameter int LockCount       = 4,
    parameter int OutPulseWidth   = 1920,
    parameter int SyncStages      = 2,
    localparam int PW = period_width(ClocksPerSecond, PeriodTolerance)
) (
    input  logic          clk_tf,
    input  logic          rst,
    input  logic          pps_raw,
    output logic          pps_raw_logic,
    output logic          pps_accept,
    output logic          pps_locked,
    output logic          period_err,
    output logic          pps_missing,
    output logic [PW-1:0] last_period
);

    localparam logic [PW-1:0] PeriodLo = PW'(ClocksPerSecond - PeriodTolerance);
    localparam logic [PW-1:0] PeriodHi = PW'(ClocksPerSecond + PeriodTolerance);
    localparam logic [PW-1:0] PerMax   = '1;
    localparam int GW = $clog2(LockCount + 1);
    localparam logic [GW-1:0] GoodMax  = GW'(LockCount);
    localparam int OW = $clog2(OutPulseWidth + 1);
    localparam logic [OW-1:0] OutLoad  = OW'(OutPulseWidth - 1);

    logic            accept;
    logic [PW-1:0]   per_cnt;
    logic            in_tol;
    pps_qual_state_e state, state_next;
    logic [GW-1:0]   good_cnt, good_next;
    logic            locked_next;
    logic            err_next;
    logic            miss_next;
    logic [PW-1:0]   last_next;
    logic            start_pulse;
    logic [OW-1:0]   out_cnt;

    pps_sync_filter #(
        .SyncStages    (SyncStages),
        .MinPulseWidth (MinPulseWidth)
    ) u_filter (
        .clk_tf  (clk_tf),
        .rst     (rst),
        .pps_raw (pps_raw),
        .accept  (accept)
    );

    // Counts cycles since the last accept; holds at all-ones if the input dies.
    always_ff @(posedge clk_tf or posedge rst) begin
        if (rst) begin
            per_cnt <= '0;
        end else if (accept) begin
            per_cnt <= PW'(1);
        end else if (per_cnt != PerMax) begin
            per_cnt <= per_cnt + PW'(1);
        end
    end

    assign in_tol = (per_cnt >= PeriodLo) && (per_cnt <= PeriodHi);

    always_comb begin
        state_next  = state;
        good_next   = good_cnt;
        locked_next = pps_locked;
        err_next    = 1'b0;
        miss_next   = 1'b0;
        last_next   = last_period;
        start_pulse = 1'b0;
        case (state)
            S_ACQUIRE: begin
                if (accept) begin
                    state_next = S_TRACK;
                    good_next  = '0;
                end
            end
            S_TRACK: begin
                if (accept) begin
                    last_next = per_cnt;
                    if (in_tol) begin
                        if (good_cnt != GoodMax) begin
                            good_next = good_cnt + GW'(1);
                        end
                        if (good_next == GoodMax) begin
                            locked_next = 1'b1;
                        end
                        start_pulse = locked_next;
                    end else begin
                        // A bad edge still becomes the reference for the next period.
                        err_next    = 1'b1;
                        good_next   = '0;
                        locked_next = 1'b0;
                    end
                end else if (per_cnt == PeriodHi) begin
                    miss_next   = 1'b1;
                    good_next   = '0;
                    locked_next = 1'b0;
                    state_next  = S_ACQUIRE;
                end
            end
            default: begin
                state_next = S_ACQUIRE;
            end
        endcase
    end

    always_ff @(posedge clk_tf or posedge rst) begin
        if (rst) begin
            state       <= S_ACQUIRE;
            good_cnt    <= '0;
            pps_locked  <= 1'b0;
            period_err  <= 1'b0;
            pps_missing <= 1'b0;
            last_period <= '0;
            pps_accept  <= 1'b0;
        end else begin
            state       <= state_next;
            good_cnt    <= good_next;
            pps_locked  <= locked_next;
            period_err  <= err_next;
            pps_missing <= miss_next;
            last_period <= last_next;
            pps_accept  <= accept;
        end
    end

    // Once started, the pulse runs to completion regardless of later lock loss.
    always_ff @(posedge clk_tf or posedge rst) begin
        if (rst) begin
            out_cnt       <= '0;
            pps_raw_logic <= 1'b0;
        end else if (start_pulse) begin
            out_cnt       <= OutLoad;
            pps_raw_logic <= 1'b1;
        end else if (out_cnt != '0) begin
            out_cnt       <= out_cnt - OW'(1);
        end else begin
            pps_raw_logic <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pps_qualifier.sv
// Scoreboard bench for pps_qualifier: directed PPS edges push expected events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_pps_qualifier;

    localparam int Cps = 1000;
    localparam int Tol = 5;
    localparam int Mpw = 4;
    localparam int Lck = 3;
    localparam int Opw = 10;
    localparam int Ss  = 2;
    localparam int Lat = Ss + Mpw;

    typedef struct {
        int cycle;
        int lastp;
        bit locked;
        bit err;
        bit pulse;
    } acc_t;

    logic       clk_tf;
    logic       rst;
    logic       pps_raw;
    logic       pps_raw_logic;
    logic       pps_accept;
    logic       pps_locked;
    logic       period_err;
    logic       pps_missing;
    logic [9:0] last_period;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    acc_t exp_acc[$];
    int   exp_miss[$];

    pps_qualifier #(
        .ClocksPerSecond (Cps),
        .PeriodTolerance (Tol),
        .MinPulseWidth   (Mpw),
        .LockCount       (Lck),
        .OutPulseWidth   (Opw),
        .SyncStages      (Ss)
    ) dut (
        .clk_tf        (clk_tf),
        .rst           (rst),
        .pps_raw       (pps_raw),
        .pps_raw_logic (pps_raw_logic),
        .pps_accept    (pps_accept),
        .pps_locked    (pps_locked),
        .period_err    (period_err),
        .pps_missing   (pps_missing),
        .last_period   (last_period)
    );

    initial begin
        clk_tf = 1'b0;
        forever #5 clk_tf = ~clk_tf;
    end

    always @(posedge clk_tf) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic waitCycle(input int n);
        while (cyc < n) begin
            @(posedge clk_tf);
            #1;
        end
    endtask

    task automatic applyStimulus(input int start, input int width);
        waitCycle(start);
        pps_raw = 1'b1;
        waitCycle(start + width);
        pps_raw = 1'b0;
    endtask

    task automatic expectAccept(input int cycle, input int lastp, input bit locked,
                                input bit err, input bit pulse);
        acc_t e;
        e.cycle  = cycle;
        e.lastp  = lastp;
        e.locked = locked;
        e.err    = err;
        e.pulse  = pulse;
        exp_acc.push_back(e);
    endtask

    task automatic ppsEdge(input int start, input int lastp, input bit locked,
                           input bit err, input bit pulse);
        expectAccept(start + Lat, lastp, locked, err, pulse);
        applyStimulus(start, 50);
    endtask

    // Monitor: every accept, missing and output pulse is matched against the queues.
    always @(negedge clk_tf) begin : monitor
        static bit   prev_raw  = 1'b0;
        static int   pulse_len = 0;
        static acc_t e;
        bit          rise;
        if (rst) begin
            prev_raw  = 1'b0;
            pulse_len = 0;
        end else begin
            rise = pps_raw_logic && !prev_raw;
            if (pps_accept) begin
                checkOutput("accept_expected", int'(exp_acc.size() != 0), 1);
                if (exp_acc.size() != 0) begin
                    e = exp_acc.pop_front();
                    checkOutput("accept_cycle", cyc, e.cycle);
                    checkOutput("last_period", int'(last_period), e.lastp);
                    checkOutput("pps_locked_at_accept", int'(pps_locked), int'(e.locked));
                    checkOutput("period_err_at_accept", int'(period_err), int'(e.err));
                    checkOutput("pulse_start_at_accept", int'(rise), int'(e.pulse));
                end
            end else begin
                if (period_err) checkOutput("period_err_with_accept", int'(pps_accept), 1);
                if (rise) checkOutput("pulse_start_with_accept", int'(pps_accept), 1);
            end
            if (pps_missing) begin
                checkOutput("missing_expected", int'(exp_miss.size() != 0), 1);
                if (exp_miss.size() != 0) begin
                    checkOutput("missing_cycle", cyc, exp_miss.pop_front());
                    checkOutput("locked_at_missing", int'(pps_locked), 0);
                end
            end
            if (pps_raw_logic) begin
                pulse_len++;
            end else if (prev_raw) begin
                checkOutput("pulse_width", pulse_len, Opw);
                pulse_len = 0;
            end
            prev_raw = pps_raw_logic;
        end
    end

    initial begin
        int b, a, c, d, r;
        rst     = 1'b1;
        pps_raw = 1'b0;
        @(posedge clk_tf);
        #1;
        waitCycle(3);
        checkOutput("reset_raw_logic", int'(pps_raw_logic), 0);
        checkOutput("reset_accept", int'(pps_accept), 0);
        checkOutput("reset_locked", int'(pps_locked), 0);
        checkOutput("reset_period_err", int'(period_err), 0);
        checkOutput("reset_missing", int'(pps_missing), 0);
        checkOutput("reset_last_period", int'(last_period), 0);
        rst = 1'b0;

        $display("[TB] test 1: lock on five nominal edges");
        b = 20;
        for (int k = 0; k < 5; k++) begin
            ppsEdge(b + 1000 * k, (k == 0) ? 0 : 1000, k >= 3, 1'b0, k >= 3);
        end

        $display("[TB] test 2: short glitch while locked");
        applyStimulus(b + 4500, 3);
        ppsEdge(b + 5000, 1000, 1'b1, 1'b0, 1'b1);

        $display("[TB] test 3: early edge, then boundary periods relock");
        ppsEdge(b + 5994, 994, 1'b0, 1'b1, 1'b0);
        ppsEdge(b + 6989, 995, 1'b0, 1'b0, 1'b0);
        ppsEdge(b + 7994, 1005, 1'b0, 1'b0, 1'b0);
        ppsEdge(b + 8994, 1000, 1'b1, 1'b0, 1'b1);

        $display("[TB] test 4: input stops while locked");
        a = b + 8994 + Lat;
        exp_miss.push_back(a + Cps + Tol);
        waitCycle(a + Cps + Tol + 5);
        checkOutput("locked_after_timeout", int'(pps_locked), 0);

        $display("[TB] test 5: input held high");
        c = b + 11000;
        expectAccept(c + Lat, 1000, 1'b0, 1'b0, 1'b0);
        exp_miss.push_back(c + Lat + Cps + Tol);
        applyStimulus(c, 3000);
        waitCycle(c + 3100);

        $display("[TB] test 6: reset during an output pulse");
        d = c + 3200;
        ppsEdge(d, 1000, 1'b0, 1'b0, 1'b0);
        ppsEdge(d + 1000, 1000, 1'b0, 1'b0, 1'b0);
        ppsEdge(d + 2000, 1000, 1'b0, 1'b0, 1'b0);
        expectAccept(d + 3000 + Lat, 1000, 1'b1, 1'b0, 1'b1);
        waitCycle(d + 3000);
        pps_raw = 1'b1;
        waitCycle(d + 3000 + Lat + 2);
        checkOutput("pulse_high_before_reset", int'(pps_raw_logic), 1);
        rst = 1'b1;
        #1;
        checkOutput("pulse_dropped_by_reset", int'(pps_raw_logic), 0);
        checkOutput("locked_in_reset", int'(pps_locked), 0);
        checkOutput("last_period_in_reset", int'(last_period), 0);
        waitCycle(d + 3050);
        pps_raw = 1'b0;
        waitCycle(d + 3070);
        rst = 1'b0;
        r = d + 3100;
        ppsEdge(r, 0, 1'b0, 1'b0, 1'b0);
        ppsEdge(r + 1000, 1000, 1'b0, 1'b0, 1'b0);
        ppsEdge(r + 2000, 1000, 1'b0, 1'b0, 1'b0);
        ppsEdge(r + 3000, 1000, 1'b1, 1'b0, 1'b1);
        waitCycle(r + 3100);

        checkOutput("accepts_outstanding", exp_acc.size(), 0);
        checkOutput("missing_outstanding", exp_miss.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
